zegar_licznik: RTL and testbench
================================

Name: zegar_licznik

Overview:
- Consumer end of the divided-clock interface: takes the slow `div_clk` square wave from the clock divider and turns it into wall-clock time.
- Runs entirely in the `clk_i` domain. Synchronises `div_clk_i`, detects its rising edges, prescales them into 1 s ticks and keeps a BCD HH:MM:SS time-of-day counter.
- Supports a validated load of the time and a run/pause control.
- Feeds the display/multiplex logic.

Parameters:
- TICKS_PER_SEC, 4, number of div_clk_i rising edges per second; legal range 1..65535.
- PRESC_W, 16, prescaler counter width; must hold TICKS_PER_SEC-1.

Ports:
- clk_i  input  1  system clock (100 MHz).
- rst_i  input  1  asynchronous, active-high reset.
- div_clk_i  input  1  divided clock from the divider; treated as asynchronous data, never used as a clock.
- run_i  input  1  1 = count; 0 = hold time, edges ignored.
- load_i  input  1  single-cycle load strobe.
- hh_i  input  8  BCD hours to load.
- mm_i  input  8  BCD minutes to load.
- ss_i  input  8  BCD seconds to load.
- hh_o  output  8  BCD hours, 00..23.
- mm_o  output  8  BCD minutes, 00..59.
- ss_o  output  8  BCD seconds, 00..59.
- sec_pulse_o  output  1  one-cycle pulse on every seconds increment.
- day_wrap_o  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
- load_ack_o  output  1  one-cycle pulse, load accepted.
- load_err_o  output  1  one-cycle pulse, load rejected.

Behaviour:
- Reset (rst_i=1, asynchronous, active-high):
  - sync flops s1..s3, prescaler and all time registers go to 0;
  - all outputs are 0 (time reads 00:00:00).
- Synchroniser and edge detect:
  - div_clk_i is registered into s1 -> s2 -> s3.
  - edge = s2 & ~s3.
  - If div_clk_i rises before clk_i edge k, the time registers update at edge k+2.
  - No edge is generated while div_clk_i is held constant.
- Prescaler:
  - On edge with run_i=1: if presc == TICKS_PER_SEC-1, presc <= 0 and a second tick is issued; otherwise presc <= presc+1.
  - With run_i=0, presc and time hold; edges during pause are lost, not queued.
- Time counter (BCD, per digit), on each second tick:
  - ss units 9 -> 0 carries into ss tens; ss 59 -> 00 carries into mm.
  - mm follows the same rules; mm 59 -> 00 carries into hh.
  - hh: units 9 -> 0 carries into tens except at 23; hh 23 -> 00.
  - On 23:59:59 -> 00:00:00, day_wrap_o pulses in the same cycle as sec_pulse_o.
- Pulse timing: sec_pulse_o, day_wrap_o, load_ack_o and load_err_o are registered, 1 cycle wide, and aligned with the cycle in which the new time is visible on the outputs.
- Load:
  - Validation: each BCD digit ≤ 9, ss ≤ 0x59, mm ≤ 0x59, hh ≤ 0x23.
  - Valid load: hh/mm/ss_o take the inputs at the next clk_i edge, presc <= 0, load_ack_o pulses.
  - Invalid load: time and presc are unchanged, load_err_o pulses.
- Simultaneous events:
  - load_i together with a second tick: load wins, the tick is discarded, no sec_pulse_o.
  - load_i with run_i=0: the load is still performed.
  - edge and reset together: reset wins.
- Reset mid-operation: everything clears at once; the first count after release needs a fresh rising edge seen through s2/s3.
- Outputs never take non-BCD or out-of-range values under any input sequence.

Test Plan:
- Reset then run_i=1, TICKS_PER_SEC=4, 8 div_clk_i rising edges -> ss_o=0x02, exactly 2 sec_pulse_o pulses, each 2 clk_i cycles after the 4th/8th edge reaches the input.
- Load 23:59:58 (ack pulses), then 8 edges -> 23:59:59, then 00:00:00 with day_wrap_o=1 for one cycle alongside sec_pulse_o.
- Load hh=0x24, then ss=0x5A, then mm=0x60 -> load_err_o pulses each time, time unchanged, load_ack_o stays 0.
- Load 12:34:56 on the same cycle the 4th edge would tick -> outputs 12:34:56, no sec_pulse_o, presc=0; the next tick needs 4 more edges.
- run_i=0 for 10 edges, then run_i=1 for 4 edges -> ss_o advances by exactly 1.
- Assert rst_i asynchronously mid-count at 00:00:37 between clk_i edges -> outputs 00:00:00 immediately; after release the first second tick needs 4 fresh edges.

Source files
------------

// File: rtl/zegar_licznik.sv
// zegar_licznik: turns the slow divided clock into a BCD HH:MM:SS time of day.
// div_clk_i is sampled as data in the clk_i domain; its rising edges are
// prescaled into one-second ticks that advance a per-digit BCD counter.
// A validated load and a run/pause control are provided, and every event is
// reported by a one-cycle registered pulse aligned with the new time.

module zegar_licznik #(
    parameter int TICKS_PER_SEC = 4,
    parameter int PRESC_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       div_clk_i,
    input  logic       run_i,
    input  logic       load_i,
    input  logic [7:0] hh_i,
    input  logic [7:0] mm_i,
    input  logic [7:0] ss_i,
    output logic [7:0] hh_o,
    output logic [7:0] mm_o,
    output logic [7:0] ss_o,
    output logic       sec_pulse_o,
    output logic       day_wrap_o,
    output logic       load_ack_o,
    output logic       load_err_o
);

    localparam logic [PRESC_W-1:0] P_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] P_ZERO = '0;
    localparam logic [PRESC_W-1:0] P_ONE  = PRESC_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser and rising-edge detection
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_edge;

    // Three-flop chain: s1/s2 resolve metastability, s3 remembers the last level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= div_clk_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_edge = r_s2 & ~r_s3;

    // ------------------------------------------------------------------
    // Load validation: every nibble must be a decimal digit and each field
    // must be inside its clock range.
    // ------------------------------------------------------------------
    logic [23:0] w_load_bytes;
    logic [5:0]  w_digit_ok;
    logic        w_range_ok;
    logic        w_load_ok;
    logic        w_load_good;
    logic        w_load_bad;

    assign w_load_bytes = {hh_i, mm_i, ss_i};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit_chk
            assign w_digit_ok[gi] = (w_load_bytes[gi*4 +: 4] <= 4'd9);
        end
    endgenerate

    assign w_range_ok  = (hh_i <= 8'h23) && (mm_i <= 8'h59) && (ss_i <= 8'h59);
    assign w_load_ok   = (&w_digit_ok) && w_range_ok;
    assign w_load_good = load_i & w_load_ok;
    assign w_load_bad  = load_i & ~w_load_ok;

    // ------------------------------------------------------------------
    // Prescaler: counts accepted edges, a tick fires on the last one.
    // A load (valid or not) owns the cycle, so counting is suppressed then.
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc;
    logic               w_count;
    logic               w_presc_last;
    logic               w_tick;

    assign w_count      = w_edge & run_i & ~load_i;
    assign w_presc_last = (r_presc == P_LAST);
    assign w_tick       = w_count & w_presc_last;

    // Prescaler register: cleared by a valid load or by wrapping on a tick.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc <= P_ZERO;
        end else if (w_load_good) begin
            r_presc <= P_ZERO;
        end else if (w_count) begin
            if (w_presc_last) begin
                r_presc <= P_ZERO;
            end else begin
                r_presc <= r_presc + P_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // BCD time digits and their one-second successor
    // ------------------------------------------------------------------
    logic [3:0] r_ss_u;
    logic [3:0] r_ss_t;
    logic [3:0] r_mm_u;
    logic [3:0] r_mm_t;
    logic [3:0] r_hh_u;
    logic [3:0] r_hh_t;

    logic [3:0] w_ss_u_next;
    logic [3:0] w_ss_t_next;
    logic [3:0] w_mm_u_next;
    logic [3:0] w_mm_t_next;
    logic [3:0] w_hh_u_next;
    logic [3:0] w_hh_t_next;

    logic w_c_ss_u;
    logic w_c_ss;
    logic w_c_mm_u;
    logic w_c_mm;
    logic w_hh_23;
    logic w_day_end;

    // Carry chain: each stage only rolls when every lower digit is at its maximum.
    assign w_c_ss_u  = (r_ss_u == 4'd9);
    assign w_c_ss    = w_c_ss_u & (r_ss_t == 4'd5);
    assign w_c_mm_u  = w_c_ss & (r_mm_u == 4'd9);
    assign w_c_mm    = w_c_mm_u & (r_mm_t == 4'd5);
    assign w_hh_23   = (r_hh_t == 4'd2) & (r_hh_u == 4'd3);
    assign w_day_end = w_c_mm & w_hh_23;

    // Successor of the current time, one second later.
    always_comb begin
        w_ss_u_next = r_ss_u;
        w_ss_t_next = r_ss_t;
        w_mm_u_next = r_mm_u;
        w_mm_t_next = r_mm_t;
        w_hh_u_next = r_hh_u;
        w_hh_t_next = r_hh_t;

        w_ss_u_next = w_c_ss_u ? 4'd0 : r_ss_u + 4'd1;

        if (w_c_ss_u) begin
            w_ss_t_next = w_c_ss ? 4'd0 : r_ss_t + 4'd1;
        end

        if (w_c_ss) begin
            w_mm_u_next = w_c_mm_u ? 4'd0 : r_mm_u + 4'd1;
        end

        if (w_c_mm_u) begin
            w_mm_t_next = w_c_mm ? 4'd0 : r_mm_t + 4'd1;
        end

        if (w_c_mm) begin
            if (w_hh_23) begin
                w_hh_u_next = 4'd0;
                w_hh_t_next = 4'd0;
            end else if (r_hh_u == 4'd9) begin
                w_hh_u_next = 4'd0;
                w_hh_t_next = r_hh_t + 4'd1;
            end else begin
                w_hh_u_next = r_hh_u + 4'd1;
            end
        end
    end

    // Time register: a valid load overrides any tick in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ss_u <= 4'd0;
            r_ss_t <= 4'd0;
            r_mm_u <= 4'd0;
            r_mm_t <= 4'd0;
            r_hh_u <= 4'd0;
            r_hh_t <= 4'd0;
        end else if (w_load_good) begin
            r_ss_u <= ss_i[3:0];
            r_ss_t <= ss_i[7:4];
            r_mm_u <= mm_i[3:0];
            r_mm_t <= mm_i[7:4];
            r_hh_u <= hh_i[3:0];
            r_hh_t <= hh_i[7:4];
        end else if (w_tick) begin
            r_ss_u <= w_ss_u_next;
            r_ss_t <= w_ss_t_next;
            r_mm_u <= w_mm_u_next;
            r_mm_t <= w_mm_t_next;
            r_hh_u <= w_hh_u_next;
            r_hh_t <= w_hh_t_next;
        end
    end

    // ------------------------------------------------------------------
    // Event pulses, registered so they line up with the updated time.
    // ------------------------------------------------------------------
    logic r_sec_pulse;
    logic r_day_wrap;
    logic r_load_ack;
    logic r_load_err;

    // One-cycle strobes, default low every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sec_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
            r_load_ack  <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= w_tick;
            r_day_wrap  <= w_tick & w_day_end;
            r_load_ack  <= w_load_good;
            r_load_err  <= w_load_bad;
        end
    end

    assign hh_o        = {r_hh_t, r_hh_u};
    assign mm_o        = {r_mm_t, r_mm_u};
    assign ss_o        = {r_ss_t, r_ss_u};
    assign sec_pulse_o = r_sec_pulse;
    assign day_wrap_o  = r_day_wrap;
    assign load_ack_o  = r_load_ack;
    assign load_err_o  = r_load_err;

endmodule

// File: tb/tb_zegar_licznik.sv
// Testbench for zegar_licznik: directed scenarios followed by a random phase,
// every cycle compared against a seconds-of-day reference model.

module tb_zegar_licznik;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       div_clk = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [7:0] hh_in = 8'h00;
    logic [7:0] mm_in = 8'h00;
    logic [7:0] ss_in = 8'h00;
    logic [7:0] hh_o;
    logic [7:0] mm_o;
    logic [7:0] ss_o;
    logic       sec_pulse_o;
    logic       day_wrap_o;
    logic       load_ack_o;
    logic       load_err_o;

    zegar_licznik #(.TICKS_PER_SEC(TPS), .PRESC_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .div_clk_i   (div_clk),
        .run_i       (run),
        .load_i      (load),
        .hh_i        (hh_in),
        .mm_i        (mm_in),
        .ss_i        (ss_in),
        .hh_o        (hh_o),
        .mm_o        (mm_o),
        .ss_o        (ss_o),
        .sec_pulse_o (sec_pulse_o),
        .day_wrap_o  (day_wrap_o),
        .load_ack_o  (load_ack_o),
        .load_err_o  (load_err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state: time as seconds since midnight, edges counted.
    int tod   = 0;
    int presc = 0;
    bit e_sec, e_wrap, e_ack, e_err;
    int due_q[$];
    int n_sec  = 0;
    int n_wrap = 0;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit valid_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if (h[7:4] > 4'd9 || h[3:0] > 4'd9) return 1'b0;
        if (m[7:4] > 4'd9 || m[3:0] > 4'd9) return 1'b0;
        if (s[7:4] > 4'd9 || s[3:0] > 4'd9) return 1'b0;
        return (dec(h) <= 23) && (dec(m) <= 59) && (dec(s) <= 59);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("hh", hh_o, bcd(tod / 3600));
        chk("mm", mm_o, bcd((tod / 60) % 60));
        chk("ss", ss_o, bcd(tod % 60));
        chk("sec_pulse", {7'd0, sec_pulse_o}, {7'd0, e_sec});
        chk("day_wrap", {7'd0, day_wrap_o}, {7'd0, e_wrap});
        chk("load_ack", {7'd0, load_ack_o}, {7'd0, e_ack});
        chk("load_err", {7'd0, load_err_o}, {7'd0, e_err});
        if (sec_pulse_o === 1'b1) n_sec++;
        if (day_wrap_o === 1'b1) n_wrap++;
    endtask

    // Apply what one clock edge does to the wall clock.
    task automatic model_edge();
        bit e;
        e_sec = 0; e_wrap = 0; e_ack = 0; e_err = 0;
        if (rst) begin
            tod = 0; presc = 0; due_q.delete();
            return;
        end
        e = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            e = 1;
        end
        if (load) begin
            if (valid_time(hh_in, mm_in, ss_in)) begin
                tod   = dec(hh_in) * 3600 + dec(mm_in) * 60 + dec(ss_in);
                presc = 0;
                e_ack = 1;
            end else begin
                e_err = 1;
            end
        end else if (e && run) begin
            presc++;
            if (presc == TPS) begin
                presc  = 0;
                tod    = (tod + 1) % 86400;
                e_sec  = 1;
                e_wrap = (tod == 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    // A rise seen before edge cyc+1 reaches the time registers at edge cyc+3.
    task automatic set_div(input bit v);
        if (v && !div_clk && !rst) due_q.push_back(cyc + 3);
        div_clk = v;
    endtask

    task automatic div_edge();
        set_div(1'b1);
        repeat ($urandom_range(1, 3)) step();
        set_div(1'b0);
        repeat ($urandom_range(1, 3)) step();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hh_in = h; mm_in = m; ss_in = s;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("reset_ss", ss_o, 8'h00);
        chk("reset_hh", hh_o, 8'h00);
        rst = 1'b0;
        step();

        // Eight edges with run=1 give two seconds
        run = 1'b1;
        n_sec = 0;
        repeat (8) div_edge();
        repeat (4) step();
        chk("run8_ss", ss_o, 8'h02);
        chk("run8_pulses", 8'(n_sec), 8'd2);

        // Load 23:59:58 then roll over midnight
        do_load(8'h23, 8'h59, 8'h58);
        chk("load_ack_direct", {7'd0, load_ack_o}, 8'd1);
        n_wrap = 0;
        repeat (8) div_edge();
        repeat (4) step();
        chk("wrap_hh", hh_o, 8'h00);
        chk("wrap_ss", ss_o, 8'h00);
        chk("wrap_count", 8'(n_wrap), 8'd1);

        // Invalid loads are rejected
        do_load(8'h24, 8'h00, 8'h00);
        do_load(8'h00, 8'h00, 8'h5A);
        do_load(8'h00, 8'h60, 8'h00);
        chk("bad_load_ss", ss_o, 8'h00);
        step();

        // Load on the cycle the fourth edge would tick
        repeat (3) div_edge();
        repeat (3) step();
        set_div(1'b1);
        step();
        set_div(1'b0);
        step();
        hh_in = 8'h12; mm_in = 8'h34; ss_in = 8'h56;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("coinc_ss", ss_o, 8'h56);
        chk("coinc_no_sec", {7'd0, sec_pulse_o}, 8'd0);
        repeat (3) div_edge();
        repeat (3) step();
        chk("coinc_hold", ss_o, 8'h56);
        div_edge();
        repeat (3) step();
        chk("coinc_next", ss_o, 8'h57);

        // Paused edges are lost
        run = 1'b0;
        repeat (10) div_edge();
        repeat (3) step();
        run = 1'b1;
        repeat (4) div_edge();
        repeat (3) step();
        chk("pause_ss", ss_o, 8'h58);

        // Asynchronous reset mid-count at 00:00:37
        do_load(8'h00, 8'h00, 8'h36);
        repeat (6) div_edge();
        repeat (3) step();
        chk("pre_rst_ss", ss_o, 8'h37);
        #3;
        rst = 1'b1;
        #1;
        tod = 0; presc = 0; due_q.delete();
        chk("async_rst_ss", ss_o, 8'h00);
        chk("async_rst_hh", hh_o, 8'h00);
        repeat (3) step();
        rst = 1'b0;
        repeat (3) div_edge();
        repeat (3) step();
        chk("post_rst_hold", ss_o, 8'h00);
        div_edge();
        repeat (3) step();
        chk("post_rst_ss", ss_o, 8'h01);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) run = ~run;
            load = ($urandom_range(0, 39) == 0);
            if (load) begin
                if ($urandom_range(0, 1) == 1) begin
                    int t;
                    t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(86390, 86399))
                                                    : int'($urandom_range(0, 86399));
                    hh_in = bcd(t / 3600);
                    mm_in = bcd((t / 60) % 60);
                    ss_in = bcd(t % 60);
                end else begin
                    hh_in = 8'($urandom);
                    mm_in = 8'($urandom);
                    ss_in = 8'($urandom);
                end
            end
            set_div(($urandom_range(0, 2) == 0) ? ~div_clk : div_clk);
            step();
        end
        load = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
